kernel_mem_loader: RTL and testbench

- Write-side front end for the kernel block memory: accepts a serial stream of complex_t kernel coefficients, one per handshake, in row-major 4x4 order.
- Packs the coefficients into 2x4 half-kernel beats and drives the memory write port: write enable, write address, select and the 2x4 write data.
- Sits between the host/DMA coefficient stream and the kernel memory. The convolution datapath reads full 4x4 kernels from the other port.

---
 rtl/kernel_mem_loader_pkg.sv | 22 ++
 rtl/kernel_mem_loader_packer.sv | 60 ++++++
 rtl/kernel_mem_loader.sv | 111 +++++++++++
 tb/tb_kernel_mem_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_mem_loader_pkg.sv
// Shared types for the kernel memory write path: complex coefficient,
// half-kernel beat payload and loader FSM states.
package kernel_mem_loader_pkg;

   localparam int KERNEL_DIM = 4;
   localparam int DATA_WIDTH = 16;

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] r;
      logic signed [DATA_WIDTH-1:0] i;
   } complex_t;

   // Two kernel rows: [row within half][column]
   typedef complex_t [0:1][0:KERNEL_DIM-1] kernel_half_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/kernel_mem_loader_packer.sv
// Collects eight coefficients into a 2x4 half-kernel and issues it as a
// single registered write beat the cycle after the eighth one arrives.
module kernel_beat_packer
   import kernel_mem_loader_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         accept,
   input  complex_t     data,
   output logic [3:0]   elem_idx,
   output logic         beat_we,
   output logic         beat_select,
   output kernel_half_t beat_data
);

   kernel_half_t stage_reg;
   kernel_half_t merged;
   logic [3:0]   elem_idx_reg;
   logic         beat_we_reg;
   logic         beat_select_reg;
   kernel_half_t beat_data_reg;
   logic         beat_done;

   assign beat_done = accept && (elem_idx_reg[2:0] == 3'd7);

   // The completing element bypasses staging so the beat leaves one cycle later
   always_comb begin
      merged       = stage_reg;
      merged[1][3] = data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_reg       <= '0;
         elem_idx_reg    <= '0;
         beat_we_reg     <= 1'b0;
         beat_select_reg <= 1'b0;
         beat_data_reg   <= '0;
      end else begin
         beat_we_reg <= beat_done;
         if (clear) begin
            elem_idx_reg <= '0;
         end else if (accept) begin
            stage_reg[elem_idx_reg[2]][elem_idx_reg[1:0]] <= data;
            elem_idx_reg <= elem_idx_reg + 4'd1;
         end
         if (beat_done) begin
            beat_select_reg <= elem_idx_reg[3];
            beat_data_reg   <= merged;
         end
      end
   end

   assign elem_idx    = elem_idx_reg;
   assign beat_we     = beat_we_reg;
   assign beat_select = beat_select_reg;
   assign beat_data   = beat_data_reg;

endmodule

// File: rtl/kernel_mem_loader.sv
// Write-side front end of the kernel memory: sequences a load of N 4x4
// kernels from a coefficient stream into half-kernel memory writes.
module kernel_mem_loader
   import kernel_mem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH  = 9,
   parameter int COUNT_WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [COUNT_WIDTH-1:0] num_kernels,
   input  logic                   s_valid,
   input  complex_t               s_data,
   output logic                   s_ready,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_write_address,
   output logic                   mem_select,
   output kernel_half_t           mem_in,
   output logic                   busy,
   output logic                   done
);

   state_t                 state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  base_reg;
   logic [ADDR_WIDTH-1:0]  address_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic [COUNT_WIDTH-1:0] kernel_idx_reg;
   logic                   done_reg;
   logic                   launch;
   logic                   xfer;
   logic                   kernel_end;
   logic                   last_kernel;
   logic [3:0]             elem_idx;

   assign xfer        = s_valid && (state_reg == ST_LOAD);
   assign kernel_end  = xfer && (elem_idx == 4'd15);
   assign last_kernel = (kernel_idx_reg == count_reg - COUNT_WIDTH'(1));

   always_comb begin
      state_next = state_reg;
      s_ready    = 1'b0;
      busy       = 1'b0;
      launch     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (num_kernels == '0) begin
                  state_next = ST_FINISH;
               end else begin
                  launch     = 1'b1;
                  state_next = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (kernel_end && last_kernel) begin
               state_next = ST_FINISH;
            end
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         base_reg       <= '0;
         address_reg    <= '0;
         count_reg      <= '0;
         kernel_idx_reg <= '0;
         done_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         // done trails FINISH by a register so it lands one cycle after the last beat
         done_reg  <= (state_reg == ST_FINISH);
         if (launch) begin
            base_reg       <= base_addr;
            count_reg      <= num_kernels;
            kernel_idx_reg <= '0;
         end else begin
            if (xfer && (elem_idx[2:0] == 3'd7)) begin
               address_reg <= base_reg + kernel_idx_reg[ADDR_WIDTH-1:0];
            end
            if (kernel_end) begin
               kernel_idx_reg <= kernel_idx_reg + COUNT_WIDTH'(1);
            end
         end
      end
   end

   kernel_beat_packer u_packer (
      .clk         (clk),
      .reset       (reset),
      .clear       (launch),
      .accept      (xfer),
      .data        (s_data),
      .elem_idx    (elem_idx),
      .beat_we     (mem_we),
      .beat_select (mem_select),
      .beat_data   (mem_in)
   );

   assign mem_write_address = address_reg;
   assign done              = done_reg;

endmodule

// File: tb/tb_kernel_mem_loader.sv
// Directed + randomized bench for kernel_mem_loader; expected beats are
// derived from the row-major coefficient list of each load.
module tb_kernel_mem_loader;
   import kernel_mem_loader_pkg::*;

   localparam int AW = 9;
   localparam int CW = 10;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [AW-1:0]  base_addr = '0;
   logic [CW-1:0]  num_kernels = '0;
   logic           s_valid = 1'b0;
   complex_t       s_data = '0;
   logic           s_ready, mem_we, mem_select, busy, done;
   logic [AW-1:0]  mem_write_address;
   kernel_half_t   mem_in;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int ready_cnt = 0;

   typedef struct {
      int           cyc;
      logic [AW-1:0] addr;
      logic         sel;
      kernel_half_t data;
   } beat_t;

   beat_t    beats[$];
   int       done_cycles[$];
   complex_t elems[$];

   kernel_mem_loader #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .base_addr         (base_addr),
      .num_kernels       (num_kernels),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .mem_we            (mem_we),
      .mem_write_address (mem_write_address),
      .mem_select        (mem_select),
      .mem_in            (mem_in),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         if (mem_we) beats.push_back('{cyc, mem_write_address, mem_select, mem_in});
         if (done) done_cycles.push_back(cyc);
         if (s_ready) ready_cnt <= ready_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      tests++;
      fails++;
      $error("FAIL %s: observed timeout expected completion", tag);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic gen_elems(input int n, input bit ramp);
      elems.delete();
      for (int j = 0; j < 16 * n; j++) begin
         if (ramp) elems.push_back(complex_t'({16'(j % 16), 16'(100 + j % 16)}));
         else      elems.push_back(complex_t'($urandom));
      end
   endtask

   task automatic start_load(input int base, input int n);
      base_addr   = AW'(base);
      num_kernels = CW'(n);
      start       = 1'b1;
      step();
      start       = 1'b0;
   endtask

   // mode 0: continuous, 1: valid toggles 1,0,1,0, 2: random valid
   task automatic stream(input int mode, input int stray_at, input int count);
      int idx = 0;
      int guard = 0;
      bit v;
      bit stray_done = 1'b0;
      while (idx < count) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = 1'(($urandom_range(0, 3) != 0));
         endcase
         s_valid = v;
         s_data  = elems[idx];
         start   = 1'b0;
         if (idx == stray_at && !stray_done) begin
            start       = 1'b1;
            base_addr   = AW'(3);
            num_kernels = CW'(1);
            stray_done  = 1'b1;
         end
         if (v && s_ready) idx++;
         step();
         guard++;
         if (guard > 4 * count + 50) begin
            fail_now("stream_timeout");
            break;
         end
      end
      s_valid = 1'b0;
      start   = 1'b0;
   endtask

   task automatic wait_done();
      int guard = 0;
      while (done_cycles.size() == 0 && guard < 20) begin
         step();
         guard++;
      end
      if (done_cycles.size() == 0) fail_now("done_timeout");
      step();
      step();
   endtask

   task automatic check_load(input string tag, input int base, input int n);
      kernel_half_t e;
      int k, h;
      chk({tag, " beat_count"}, 256'(beats.size()), 256'(2 * n));
      for (int b = 0; b < beats.size() && b < 2 * n; b++) begin
         k = b / 2;
         h = b % 2;
         for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
               e[r][c] = elems[k * 16 + h * 8 + r * 4 + c];
         chk({tag, " addr"}, 256'(beats[b].addr), 256'((base + k) % (1 << AW)));
         chk({tag, " select"}, 256'(beats[b].sel), 256'(h));
         chk({tag, " data"}, 256'(beats[b].data), 256'(e));
      end
      chk({tag, " done_count"}, 256'(done_cycles.size()), 256'(1));
      if (done_cycles.size() > 0 && beats.size() > 0)
         chk({tag, " done_latency"}, 256'(done_cycles[0]), 256'(beats[beats.size() - 1].cyc + 1));
      chk({tag, " hold_addr"}, 256'(mem_write_address), 256'((base + n - 1) % (1 << AW)));
      chk({tag, " hold_we_sel"}, 256'({mem_we, mem_select}), 256'(2'b01));
   endtask

   task automatic run(input string tag, input int base, input int n, input bit ramp,
                      input int mode, input int stray_at);
      beats.delete();
      done_cycles.delete();
      gen_elems(n, ramp);
      start_load(base, n);
      stream(mode, stray_at, 16 * n);
      wait_done();
      check_load(tag, base, n);
      $display("[TB] load %s base=%0d kernels=%0d beats=%0d dones=%0d", tag, base, n,
               beats.size(), done_cycles.size());
   endtask

   initial begin
      int c0, r0;
      reset = 1'b0;
      step();
      step();
      chk("reset_outputs", 256'({s_ready, mem_we, mem_select, busy, done, mem_write_address}), 256'(0));
      chk("reset_mem_in", 256'(mem_in), 256'(0));
      reset = 1'b1;
      step();

      run("single", 5, 1, 1'b1, 0, -1);
      run("throttled", 5, 1, 1'b1, 1, -1);
      run("wrap", 510, 3, 1'b0, 0, -1);
      run("random_valid", 100, 2, 1'b0, 2, -1);
      run("stray_start", 20, 2, 1'b0, 0, 20);

      // zero-count load
      beats.delete();
      done_cycles.delete();
      c0 = cyc;
      r0 = ready_cnt;
      start_load(0, 0);
      repeat (5) step();
      chk("zero beats", 256'(beats.size()), 256'(0));
      chk("zero done_count", 256'(done_cycles.size()), 256'(1));
      if (done_cycles.size() > 0) chk("zero done_cycle", 256'(done_cycles[0]), 256'(c0 + 2));
      chk("zero ready", 256'(ready_cnt), 256'(r0));
      $display("[TB] load zero_count dones=%0d", done_cycles.size());

      // reset in the middle of a two-kernel load
      beats.delete();
      done_cycles.delete();
      gen_elems(2, 1'b0);
      start_load(40, 2);
      stream(0, -1, 11);
      chk("midreset beats_before", 256'(beats.size()), 256'(1));
      reset = 1'b0;
      for (int j = 0; j < 3; j++) begin
         #1;
         chk("midreset outputs", 256'({s_ready, mem_we, mem_select, busy, done, mem_write_address}), 256'(0));
         chk("midreset mem_in", 256'(mem_in), 256'(0));
         step();
      end
      reset = 1'b1;
      repeat (4) step();
      chk("midreset no_done", 256'(done_cycles.size()), 256'(0));
      chk("midreset idle", 256'({busy, s_ready}), 256'(0));
      $display("[TB] load reset_abort beats=%0d dones=%0d", beats.size(), done_cycles.size());
      run("after_reset", 7, 1, 1'b0, 2, -1);

      run("full_range", 0, 512, 1'b0, 0, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
